// File: rtl/tdp_bram_clr_if.sv
// One port of the tdp_bram_clr RAM: enable, byte write enables, address, write data
// and the returned read data with its valid flag.
interface tdp_bram_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  ce;
  logic [NB-1:0]         we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] qout;
  logic                  qvalid;

  modport master (output ce, we, addr, din, input qout, qvalid);
  modport slave  (input ce, we, addr, din, output qout, qvalid);
endinterface

// File: rtl/tdp_bram_clr.sv
// Single-clock true dual-port RAM with byte enables, read-during-write modes, optional
// output register and a full-array clear engine. Define TDP_BRAM_COLL_DET_EN for collision detection.
module tdp_bram_clr #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   BYTE_WIDTH = 8,
  parameter int                   ADDR_WIDTH = 12,
  parameter int                   MEM_SIZE   = 4096,
  parameter int                   RD_MODE    = 0,
  parameter int                   OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  tdp_bram_clr_if.slave         port_a,
  tdp_bram_clr_if.slave         port_b,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  coll_err,
  output logic [ADDR_WIDTH-1:0] coll_addr
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_e;

  clr_state_e            state;
  logic [IDX_W-1:0]      clr_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // Index 0 is port A, index 1 is port B.
  logic                  p_ce   [2];
  logic [NB-1:0]         p_we   [2];
  logic [ADDR_WIDTH-1:0] p_addr [2];
  logic [DATA_WIDTH-1:0] p_din  [2];
  logic [IDX_W-1:0]      p_idx  [2];
  logic                  acc    [2];
  logic                  wr     [2];
  logic                  inr    [2];
  logic [DATA_WIDTH-1:0] old_w  [2];
  logic [DATA_WIDTH-1:0] new_w  [2];
  logic [DATA_WIDTH-1:0] s1_q   [2];
  logic                  s1_v   [2];
  logic                  same_addr;

  assign p_ce[0]   = port_a.ce;
  assign p_we[0]   = port_a.we;
  assign p_addr[0] = port_a.addr;
  assign p_din[0]  = port_a.din;
  assign p_ce[1]   = port_b.ce;
  assign p_we[1]   = port_b.we;
  assign p_addr[1] = port_b.addr;
  assign p_din[1]  = port_b.din;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]   = p_ce[p] && !clr_busy;
      wr[p]    = acc[p] && (|p_we[p]);
      inr[p]   = {1'b0, p_addr[p]} < (ADDR_WIDTH+1)'(MEM_SIZE);
      p_idx[p] = p_addr[p][IDX_W-1:0];
      old_w[p] = inr[p] ? mem[p_idx[p]] : '0;
    end
  end

  assign same_addr = wr[0] && wr[1] && (p_addr[0] == p_addr[1]);

  // Word each port's address holds after this edge; on a shared address both ports
  // see the same result, with port A lanes laid over port B lanes.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned and no latch is inferred.
    new_w[0] = old_w[0];
    new_w[1] = old_w[1];
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (p_we[1][i] && (p == 1 || same_addr))
          new_w[p][i*BYTE_WIDTH +: BYTE_WIDTH] = p_din[1][i*BYTE_WIDTH +: BYTE_WIDTH];
        if (p_we[0][i] && (p == 0 || same_addr))
          new_w[p][i*BYTE_WIDTH +: BYTE_WIDTH] = p_din[0][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst and a reset-free array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_busy) begin
        mem[clr_addr] <= INIT_VAL;
      end else begin
        // Port A lanes are written last so they win a same-address, same-lane write.
        for (int i = 0; i < NB; i++) begin
          if (wr[1] && inr[1] && p_we[1][i])
            mem[p_idx[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[1][i*BYTE_WIDTH +: BYTE_WIDTH];
          if (wr[0] && inr[0] && p_we[0][i])
            mem[p_idx[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[0][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // NOTE: nonblocking assignments everywhere, so reads taken at an edge see pre-edge contents (old word on cross-port reads).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        s1_q[p] <= '0;
        s1_v[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_v[p] <= 1'b0;
        if (acc[p]) begin
          if (!wr[p]) begin
            s1_q[p] <= old_w[p];
            s1_v[p] <= 1'b1;
          end else if (RD_MODE == 1) begin
            s1_q[p] <= new_w[p];
            s1_v[p] <= 1'b1;
          end else if (RD_MODE == 0) begin
            s1_q[p] <= old_w[p];
            s1_v[p] <= 1'b1;
          end
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_q [2];
      logic                  s2_v [2];

      // Keeps advancing during a clear so reads already issued still emerge.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int p = 0; p < 2; p++) begin
            s2_q[p] <= '0;
            s2_v[p] <= 1'b0;
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            s2_v[p] <= s1_v[p];
            if (s1_v[p]) s2_q[p] <= s1_q[p];
          end
        end
      end

      assign port_a.qout   = s2_q[0];
      assign port_a.qvalid = s2_v[0];
      assign port_b.qout   = s2_q[1];
      assign port_b.qvalid = s2_v[1];
    end else begin : g_no_out_reg
      assign port_a.qout   = s1_q[0];
      assign port_a.qvalid = s1_v[0];
      assign port_b.qout   = s1_q[1];
      assign port_b.qvalid = s1_v[1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == IDX_W'(MEM_SIZE - 1)) begin
            state    <= ST_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDP_BRAM_COLL_DET_EN
  // Records only the first overlapping same-address dual write until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_err  <= 1'b0;
      coll_addr <= '0;
    end else if (!coll_err && same_addr && inr[0] && (|(p_we[0] & p_we[1]))) begin
      coll_err  <= 1'b1;
      coll_addr <= p_addr[0];
    end
  end
`else
  assign coll_err  = 1'b0;
  assign coll_addr = '0;
`endif

endmodule

// File: tb/tb_tdp_bram_clr.sv
// Drives four RAM configurations (RD_MODE/OUT_REG combinations) with identical stimulus
// and compares every output each cycle against a word-level reference model.
module tb_tdp_bram_clr;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 5;
  localparam int MS = 16;
  localparam int NB = DW / BW;
  localparam int NCFG = 4;
  localparam logic [DW-1:0] INIT = 32'hC1EA_50F0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ce_a, ce_b;
  logic [NB-1:0] we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          clr_start;

  logic [DW-1:0] obs_qa [NCFG];
  logic [DW-1:0] obs_qb [NCFG];
  logic          obs_va [NCFG];
  logic          obs_vb [NCFG];
  logic          obs_busy [NCFG];
  logic          obs_done [NCFG];
  logic          obs_coll [NCFG];
  logic [AW-1:0] obs_caddr [NCFG];

  // cfg g: RD_MODE = g % 3, OUT_REG = g odd -> (0,0) (1,1) (2,0) (0,1)
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    tdp_bram_clr_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_a ();
    tdp_bram_clr_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_b ();

    assign if_a.ce   = ce_a;
    assign if_a.we   = we_a;
    assign if_a.addr = addr_a;
    assign if_a.din  = din_a;
    assign if_b.ce   = ce_b;
    assign if_b.we   = we_b;
    assign if_b.addr = addr_b;
    assign if_b.din  = din_b;
    assign obs_qa[g] = if_a.qout;
    assign obs_va[g] = if_a.qvalid;
    assign obs_qb[g] = if_b.qout;
    assign obs_vb[g] = if_b.qvalid;

    tdp_bram_clr #(
      .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_SIZE(MS),
      .RD_MODE(g % 3), .OUT_REG((g % 2 == 1) ? 1 : 0), .INIT_VAL(INIT)
    ) dut (
      .clk(clk), .rst(rst), .port_a(if_a), .port_b(if_b),
      .clr_start(clr_start), .clr_busy(obs_busy[g]), .clr_done(obs_done[g]),
      .coll_err(obs_coll[g]), .coll_addr(obs_caddr[g])
    );
  end

  // Reference model state
  logic [DW-1:0] ref_mem [MS];
  int            clr_k;            // -1 idle, 1..MS clearing word clr_k-1, MS+1 done
  logic [DW-1:0] exp_q  [2][NCFG];
  logic          exp_v  [2][NCFG];
  logic [DW-1:0] pend_q [2][NCFG];
  logic          pend_v [2][NCFG];
  logic          exp_coll;
  logic [AW-1:0] exp_caddr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [DW-1:0] w, input logic [NB-1:0] we,
                                          input logic [DW-1:0] d);
    for (int i = 0; i < NB; i++)
      if (we[i]) w[i*BW +: BW] = d[i*BW +: BW];
    return w;
  endfunction

  function automatic logic [DW-1:0] word_at(input int x);
    return (x < MS) ? ref_mem[x] : '0;
  endfunction

  // Contents of address x after this cycle's writes: B applied first, then A on top.
  function automatic logic [DW-1:0] final_word(input int x, input bit wra, input bit wrb);
    logic [DW-1:0] w;
    w = word_at(x);
    if (wrb && int'(addr_b) == x) w = lanes(w, we_b, din_b);
    if (wra && int'(addr_a) == x) w = lanes(w, we_a, din_a);
    return w;
  endfunction

  task automatic model_step();
    bit            busy, rv;
    bit            acc [2];
    bit            wr  [2];
    int            ad  [2];
    logic [DW-1:0] old [2];
    logic [DW-1:0] fin [2];
    logic [DW-1:0] rd;
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int g = 0; g < NCFG; g++) begin
          exp_q[p][g] = '0; exp_v[p][g] = 1'b0;
          pend_q[p][g] = '0; pend_v[p][g] = 1'b0;
        end
      clr_k = -1;
      exp_coll = 1'b0;
      exp_caddr = '0;
      return;
    end
    busy   = (clr_k >= 1) && (clr_k <= MS);
    acc[0] = ce_a && !busy;
    acc[1] = ce_b && !busy;
    wr[0]  = acc[0] && (we_a != '0);
    wr[1]  = acc[1] && (we_b != '0);
    ad[0]  = int'(addr_a);
    ad[1]  = int'(addr_b);
    for (int p = 0; p < 2; p++) begin
      old[p] = word_at(ad[p]);
      fin[p] = final_word(ad[p], wr[0], wr[1]);
    end
    for (int g = 0; g < NCFG; g++) begin
      for (int p = 0; p < 2; p++) begin
        rv = 1'b0;
        rd = '0;
        if (acc[p]) begin
          if (!wr[p]) begin
            rv = 1'b1; rd = old[p];
          end else if (g % 3 == 0) begin
            rv = 1'b1; rd = old[p];
          end else if (g % 3 == 1) begin
            rv = 1'b1; rd = fin[p];
          end
        end
        if (g % 2 == 1) begin
          exp_v[p][g] = pend_v[p][g];
          if (pend_v[p][g]) exp_q[p][g] = pend_q[p][g];
          pend_v[p][g] = rv;
          pend_q[p][g] = rd;
        end else begin
          exp_v[p][g] = rv;
          if (rv) exp_q[p][g] = rd;
        end
      end
    end
`ifdef TDP_BRAM_COLL_DET_EN
    if (!exp_coll && wr[0] && wr[1] && ad[0] == ad[1] && ad[0] < MS && (we_a & we_b) != '0) begin
      exp_coll  = 1'b1;
      exp_caddr = addr_a;
    end
`endif
    if (busy) ref_mem[clr_k-1] = INIT;
    else
      for (int p = 0; p < 2; p++)
        if (wr[p] && ad[p] < MS) ref_mem[ad[p]] = fin[p];
    if (clr_k == -1) begin
      if (clr_start) clr_k = 1;
    end else if (clr_k == MS + 1) begin
      clr_k = -1;
    end else begin
      clr_k++;
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("qout_a[%0d]", g),   obs_qa[g], exp_q[0][g]);
      check($sformatf("qvalid_a[%0d]", g), DW'(obs_va[g]), DW'(exp_v[0][g]));
      check($sformatf("qout_b[%0d]", g),   obs_qb[g], exp_q[1][g]);
      check($sformatf("qvalid_b[%0d]", g), DW'(obs_vb[g]), DW'(exp_v[1][g]));
      check($sformatf("clr_busy[%0d]", g), DW'(obs_busy[g]), DW'((clr_k >= 1) && (clr_k <= MS)));
      check($sformatf("clr_done[%0d]", g), DW'(obs_done[g]), DW'(clr_k == MS + 1));
      check($sformatf("coll_err[%0d]", g), DW'(obs_coll[g]), DW'(exp_coll));
      check($sformatf("coll_addr[%0d]", g), DW'(obs_caddr[g]), DW'(exp_caddr));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input bit ca, input logic [NB-1:0] wa, input int aa, input logic [DW-1:0] da,
                       input bit cb, input logic [NB-1:0] wb, input int ab, input logic [DW-1:0] db);
    ce_a = ca; we_a = wa; addr_a = AW'(aa); din_a = da;
    ce_b = cb; we_b = wb; addr_b = AW'(ab); din_b = db;
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    clr_start = 1'b0;
    idle();
    clr_k = -1;
    exp_coll = 1'b0;
    exp_caddr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full clear with writes attempted while busy
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("busy_after_start", DW'(obs_busy[0]), 32'd1);
    for (int k = 0; k < 15; k++) begin
      drive(1, 4'hF, k, $urandom, 0, '0, 0, '0);
      tick();
    end
    idle();
    tick();
    check("done_at_t17", DW'(obs_done[0]), 32'd1);
    check("busy_off_at_t17", DW'(obs_busy[0]), 32'd0);
    tick();
    for (int i = 0; i < MS; i++) begin
      drive(1, '0, i, '0, 1, '0, MS - 1 - i, '0);
      tick();
      check($sformatf("cleared_word_%0d", i), obs_qa[0], INIT);
    end

    // Fill with random data from both ports
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'hF, i, $urandom, 1, 4'hF, i + 8, $urandom);
      tick();
    end

    // Write then cross-port read
    drive(1, 4'hF, 5, 32'hDEADBEEF, 0, '0, 0, '0);
    tick();
    drive(0, '0, 0, '0, 1, '0, 5, '0);
    tick();
    check("xport_read_data", obs_qb[0], 32'hDEADBEEF);
    check("xport_read_valid", DW'(obs_vb[0]), 32'd1);

    // Byte lanes
    drive(1, 4'hF, 7, 32'h11223344, 0, '0, 0, '0);
    tick();
    drive(1, 4'b0101, 7, 32'hAABBCCDD, 0, '0, 0, '0);
    tick();
    drive(1, '0, 7, '0, 0, '0, 0, '0);
    tick();
    check("byte_lanes", obs_qa[0], 32'h11BB33DD);

    // Read-during-write modes
    drive(1, 4'hF, 3, 32'h1, 0, '0, 0, '0);
    tick();
    drive(1, 4'hF, 3, 32'h2, 0, '0, 0, '0);
    tick();
    check("rdw_read_first", obs_qa[0], 32'h1);
    check("rdw_no_change_hold", obs_qa[2], 32'h11BB33DD);
    check("rdw_no_change_valid", DW'(obs_va[2]), 32'd0);
    idle();
    tick();
    check("rdw_write_first_oreg", obs_qa[1], 32'h2);
    check("rdw_write_first_valid", DW'(obs_va[1]), 32'd1);

    // OUT_REG streaming on port B
    drive(0, '0, 0, '0, 1, '0, 5, '0);
    tick();
    drive(0, '0, 0, '0, 1, '0, 7, '0);
    tick();
    check("stream_0", obs_qb[1], 32'hDEADBEEF);
    drive(0, '0, 0, '0, 1, '0, 3, '0);
    tick();
    check("stream_1", obs_qb[1], 32'h11BB33DD);
    idle();
    tick();
    check("stream_2", obs_qb[1], 32'h2);
    tick();
    check("stream_end_valid", DW'(obs_vb[1]), 32'd0);
    check("stream_end_hold", obs_qb[1], 32'h2);

    // Out-of-range write is dropped and read returns 0
    drive(1, 4'hF, 20, 32'h5555AAAA, 0, '0, 0, '0);
    tick();
    drive(1, '0, 20, '0, 0, '0, 0, '0);
    tick();
    check("oor_read_data", obs_qa[0], 32'h0);
    check("oor_read_valid", DW'(obs_va[0]), 32'd1);
    drive(1, '0, 4, '0, 0, '0, 0, '0);
    tick();

    // Dual writes to the same address
    drive(1, 4'hF, 9, 32'hA, 1, 4'hF, 9, 32'hB);
    tick();
`ifdef TDP_BRAM_COLL_DET_EN
    check("coll_first_err", DW'(obs_coll[0]), 32'd1);
    check("coll_first_addr", DW'(obs_caddr[0]), 32'd9);
`endif
    drive(1, '0, 9, '0, 0, '0, 0, '0);
    tick();
    check("dual_write_a_wins", obs_qa[0], 32'hA);
    drive(1, 4'b0011, 4, 32'h11111111, 1, 4'b0110, 4, 32'h22222222);
    tick();
    drive(1, '0, 4, '0, 0, '0, 0, '0);
    tick();
    check("dual_write_b_lane", {8'h0, obs_qa[0][23:0]}, 32'h00221111);
`ifdef TDP_BRAM_COLL_DET_EN
    check("coll_addr_sticky", DW'(obs_caddr[0]), 32'd9);
`endif

    // Reset in the middle of a clear
    idle();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_clear_busy", DW'(obs_busy[0]), 32'd0);
    tick();
    check("rst_mid_clear_no_done", DW'(obs_done[0]), 32'd0);
    for (int i = 0; i < MS; i++) begin
      drive(1, '0, i, '0, 1, '0, MS - 1 - i, '0);
      tick();
      if (i == 6) check("partial_clear_word6", obs_qa[0], INIT);
      if (i == 7) check("partial_clear_word7", obs_qa[0], 32'h11BB33DD);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(149) == 0);
      clr_start = ($urandom_range(59) == 0);
      drive($urandom_range(3) != 0, ($urandom_range(1) == 0) ? NB'($urandom) : '0,
            $urandom_range(MS + 3), $urandom,
            $urandom_range(3) != 0, ($urandom_range(1) == 0) ? NB'($urandom) : '0,
            $urandom_range(MS + 3), $urandom);
      tick();
    end
    rst = 1'b0;
    clr_start = 1'b0;
    idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
